mul_div_unit: RTL and testbench

//  Iterative multiply/divide engine that produces the HI/LO register write stream.

---
 rtl/mul_div_unit_pkg.sv | 27 ++
 rtl/mul_div_unit_if.sv | 29 ++
 rtl/mul_div_unit_md_step.sv | 41 ++++
 rtl/mul_div_unit.sv | 161 ++++++++++++++++
 tb/tb_mul_div_unit.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation codes,
// FSM state encoding and a small magnitude helper used when latching operands.
package mul_div_unit_pkg;

    localparam int MD_WIDTH = 32;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Two's-complement magnitude when neg is set; 0x8000_0000 maps to itself,
    // which the unsigned datapath then treats as 2^31.
    function automatic logic [MD_WIDTH-1:0] magnitude(input logic [MD_WIDTH-1:0] v,
                                                      input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Issue/write-back bundle between EX, the multiply/divide unit and HI/LO.
//
// Handshake: start is the issuer's valid and !busy is the unit's ready. An
// operation transfers on a rising clk edge where start=1, busy=0 and cancel=0;
// otherwise the issuer must hold the instruction. hlWrite is a one-cycle valid
// for dinHi/dinLo toward HI/LO with no backpressure.
interface mul_div_unit_if;
    import mul_div_unit_pkg::*;

    logic                start;
    logic [2:0]          op;
    logic [MD_WIDTH-1:0] srcA;
    logic [MD_WIDTH-1:0] srcB;
    logic                cancel;
    logic                busy;
    logic [MD_WIDTH-1:0] dinHi;
    logic [MD_WIDTH-1:0] dinLo;
    logic [1:0]          hlWrite;

    modport master (
        output start, op, srcA, srcB, cancel,
        input  busy, dinHi, dinLo, hlWrite
    );

    modport slave (
        input  start, op, srcA, srcB, cancel,
        output busy, dinHi, dinLo, hlWrite
    );
endinterface

// File: rtl/mul_div_unit_md_step.sv
// One iteration of the shared datapath over the {acc,quo} register pair:
// a shift-add multiply step (right shift) or a restoring divide step (left shift).
module md_step
    import mul_div_unit_pkg::*;
(
    input  logic                isDiv,
    input  logic [MD_WIDTH-1:0] acc,
    input  logic [MD_WIDTH-1:0] quo,
    input  logic [MD_WIDTH-1:0] operand,
    output logic [MD_WIDTH-1:0] accNext,
    output logic [MD_WIDTH-1:0] quoNext
);

    logic [MD_WIDTH:0] sum;
    logic [MD_WIDTH:0] rem;

    // Divide: shift in the next dividend bit and subtract when it fits.
    // Multiply: add the multiplicand on a set LSB, then shift the 65-bit pair right.
    always_comb begin
        accNext = acc;
        quoNext = quo;
        sum     = '0;
        rem     = '0;
        if (isDiv) begin
            rem = {acc, quo[MD_WIDTH-1]};
            if (rem >= {1'b0, operand}) begin
                // Difference is below the divisor, so the low bits hold it exactly.
                accNext = rem[MD_WIDTH-1:0] - operand;
                quoNext = {quo[MD_WIDTH-2:0], 1'b1};
            end else begin
                accNext = rem[MD_WIDTH-1:0];
                quoNext = {quo[MD_WIDTH-2:0], 1'b0};
            end
        end else begin
            sum     = {1'b0, acc} + (quo[0] ? {1'b0, operand} : {(MD_WIDTH+1){1'b0}});
            accNext = sum[MD_WIDTH:1];
            quoNext = {sum[0], quo[MD_WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide engine feeding the HI/LO register block. Signed ops
// run on magnitudes; the sign fix-up is applied as the result is registered.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH    = MD_WIDTH,
    parameter bit FAST_MUL = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    mul_div_unit_if.slave  bus,
    output state_t         dbgState
);

    state_t             state;
    logic [4:0]         counter;
    logic               isDiv;
    logic               qneg;
    logic               rneg;
    logic               divZero;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   operand;
    logic [1:0]         hlWriteReg;
    logic [WIDTH-1:0]   dinHiReg;
    logic [WIDTH-1:0]   dinLoReg;

    logic               signedOp;
    logic               sA;
    logic               sB;
    logic [WIDTH-1:0]   absA;
    logic [WIDTH-1:0]   absB;
    logic [WIDTH-1:0]   stepAcc;
    logic [WIDTH-1:0]   stepQuo;
    logic               fastStep;
    logic [2*WIDTH-1:0] rawProd;
    logic [2*WIDTH-1:0] mulRes;
    logic [WIDTH-1:0]   rawHi;
    logic [WIDTH-1:0]   rawLo;
    logic [WIDTH-1:0]   resHi;
    logic [WIDTH-1:0]   resLo;

    md_step uStep (
        .isDiv   (isDiv),
        .acc     (acc),
        .quo     (quo),
        .operand (operand),
        .accNext (stepAcc),
        .quoNext (stepQuo)
    );

    // Operand decode at issue: sign flags and magnitudes for the signed ops.
    always_comb begin
        signedOp = (bus.op == MD_MULT) || (bus.op == MD_DIV);
        sA       = signedOp & bus.srcA[WIDTH-1];
        sB       = signedOp & bus.srcB[WIDTH-1];
        absA     = magnitude(bus.srcA, sA);
        absB     = magnitude(bus.srcB, sB);
    end

    // Final result of the last RUN cycle, sign-corrected, ready to register.
    always_comb begin
        fastStep = FAST_MUL && !isDiv;
        rawProd  = {{WIDTH{1'b0}}, operand} * {{WIDTH{1'b0}}, quo};
        rawHi    = fastStep ? rawProd[2*WIDTH-1:WIDTH] : stepAcc;
        rawLo    = fastStep ? rawProd[WIDTH-1:0]       : stepQuo;
        mulRes   = qneg ? (~{rawHi, rawLo} + 1'b1) : {rawHi, rawLo};
        resHi    = mulRes[2*WIDTH-1:WIDTH];
        resLo    = mulRes[WIDTH-1:0];
        if (isDiv) begin
            // Divide by zero leaves acc = |dividend|, so the rneg fix-up returns srcA.
            resLo = divZero ? '1 : (qneg ? (~rawLo + 1'b1) : rawLo);
            resHi = rneg ? (~rawHi + 1'b1) : rawHi;
        end
    end

    // Control FSM with operand/sign registers and registered write-back outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            counter    <= '0;
            isDiv      <= 1'b0;
            qneg       <= 1'b0;
            rneg       <= 1'b0;
            divZero    <= 1'b0;
            acc        <= '0;
            quo        <= '0;
            operand    <= '0;
            hlWriteReg <= 2'b00;
            dinHiReg   <= '0;
            dinLoReg   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    hlWriteReg <= 2'b00;
                    if (bus.start && !bus.cancel) begin
                        case (bus.op)
                            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                                isDiv   <= bus.op[1];
                                qneg    <= sA ^ sB;
                                rneg    <= sA;
                                divZero <= bus.op[1] && (bus.srcB == '0);
                                acc     <= '0;
                                // Divide shifts the dividend out of quo; multiply
                                // shifts the multiplier out of quo.
                                quo     <= bus.op[1] ? absA : absB;
                                operand <= bus.op[1] ? absB : absA;
                                counter <= 5'd31;
                                state   <= S_RUN;
                            end
                            MD_MTHI: begin
                                dinHiReg   <= bus.srcA;
                                hlWriteReg <= 2'b10;
                                state      <= S_DONE;
                            end
                            MD_MTLO: begin
                                dinLoReg   <= bus.srcA;
                                hlWriteReg <= 2'b01;
                                state      <= S_DONE;
                            end
                            default: ;
                        endcase
                    end
                end
                S_RUN: begin
                    if (bus.cancel) begin
                        hlWriteReg <= 2'b00;
                        state      <= S_IDLE;
                    end else if (fastStep || counter == 5'd0) begin
                        acc        <= rawHi;
                        quo        <= rawLo;
                        dinHiReg   <= resHi;
                        dinLoReg   <= resLo;
                        hlWriteReg <= 2'b11;
                        state      <= S_DONE;
                    end else begin
                        acc     <= stepAcc;
                        quo     <= stepQuo;
                        counter <= counter - 5'd1;
                    end
                end
                S_DONE: begin
                    hlWriteReg <= 2'b00;
                    state      <= S_IDLE;
                end
                default: begin
                    hlWriteReg <= 2'b00;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

    // A flush arriving during DONE must still suppress the write that cycle.
    assign bus.hlWrite = hlWriteReg & {2{~bus.cancel}};
    assign bus.busy    = (state != S_IDLE);
    assign bus.dinHi   = dinHiReg;
    assign bus.dinLo   = dinLoReg;
    assign dbgState    = state;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: the driver pushes expected HI/LO writes
// (with their expected cycle) into a queue, and a monitor pops and compares on
// every hlWrite pulse.
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    logic   clk = 1'b0;
    logic   rst = 1'b0;
    state_t dbgState;

    mul_div_unit_if bus();

    mul_div_unit #(.WIDTH(32), .FAST_MUL(1'b0)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .dbgState (dbgState)
    );

    // Clock and edge counter.
    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int nChecks = 0;
    int nFail   = 0;

    // Entry: {expected cycle[31:0], hlWrite[1:0], hi[31:0], lo[31:0]}.
    logic [97:0] exp_q[$];
    string       name_q[$];
    logic [31:0] lastHi = '0;
    logic [31:0] lastLo = '0;
    int          kEdge  = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] expv);
        nChecks++;
        if (act !== expv) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", tag, act, expv);
        end
    endtask

    // Monitor: every write pulse must match the head of the expected queue.
    always @(negedge clk) begin : monitor
        logic [97:0] e;
        string       n;
        if (rst && bus.hlWrite != 2'b00) begin
            if (exp_q.size() == 0) begin
                nChecks++;
                nFail++;
                $display("FAIL unexpected_write: got hlWrite=%b at cycle %0d expected none",
                         bus.hlWrite, cycle);
            end else begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                check({n, "_cycle"},   64'(cycle),       64'(e[97:66]));
                check({n, "_hlWrite"}, 64'(bus.hlWrite), 64'(e[65:64]));
                check({n, "_hi"},      64'(bus.dinHi),   64'(e[63:32]));
                check({n, "_lo"},      64'(bus.dinLo),   64'(e[31:0]));
            end
        end
    end

    // Driver: called at a negedge, asserts start for one cycle and returns at the
    // negedge right after the accept edge (cycle == kEdge).
    task automatic issue(input string tag, input logic [2:0] opc, input logic [31:0] a,
                         input logic [31:0] b, input logic [1:0] hl, input logic [31:0] hi,
                         input logic [31:0] lo, input int lat);
        bus.start = 1'b1;
        bus.op    = opc;
        bus.srcA  = a;
        bus.srcB  = b;
        kEdge     = cycle + 1;
        if (hl != 2'b00) begin
            exp_q.push_back({32'(kEdge + lat), hl, hi, lo});
            name_q.push_back(tag);
            lastHi = hi;
            lastLo = lo;
        end
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic waitIdle(input string tag);
        for (int i = 0; i < 100; i++) begin
            if (!bus.busy) break;
            @(negedge clk);
        end
        check({tag, "_idle"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000ns");
        $fatal(1);
    end

    initial begin
        bus.start  = 1'b0;
        bus.op     = 3'd0;
        bus.srcA   = '0;
        bus.srcB   = '0;
        bus.cancel = 1'b0;
        rst        = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state.
        check("rst_busy",    64'(bus.busy),    64'd0);
        check("rst_hlWrite", 64'(bus.hlWrite), 64'd0);
        check("rst_dinHi",   64'(bus.dinHi),   64'd0);
        check("rst_dinLo",   64'(bus.dinLo),   64'd0);
        check("rst_state",   64'(dbgState),    64'(S_IDLE));
        rst = 1'b1;
        @(negedge clk);

        // MULTU max*max with busy timing around DONE.
        issue("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11,
              32'hFFFF_FFFE, 32'h0000_0001, 32);
        repeat (32) @(negedge clk);
        check("multu_busy_done", 64'(bus.busy), 64'd1);
        check("multu_state_done", 64'(dbgState), 64'(S_DONE));
        @(negedge clk);
        check("multu_busy_after", 64'(bus.busy), 64'd0);

        issue("mult_neg", MD_MULT, 32'hFFFF_FFFD, 32'd5, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 32);
        waitIdle("mult_neg");
        issue("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32);
        waitIdle("div_neg");
        issue("div_negb", MD_DIV, 32'd7, 32'hFFFF_FFFE, 2'b11, 32'h0000_0001, 32'hFFFF_FFFD, 32);
        waitIdle("div_negb");
        issue("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 2'b11, 32'h0, 32'h8000_0000, 32);
        waitIdle("div_ovf");
        issue("divu_zero", MD_DIVU, 32'd5, 32'd0, 2'b11, 32'h0000_0005, 32'hFFFF_FFFF, 32);
        waitIdle("divu_zero");
        issue("div_zero", MD_DIV, 32'hFFFF_FFF9, 32'd0, 2'b11, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32);
        waitIdle("div_zero");
        issue("mult_min", MD_MULT, 32'h8000_0000, 32'h8000_0000, 2'b11, 32'h4000_0000, 32'h0, 32);
        waitIdle("mult_min");
        issue("divu_100_7", MD_DIVU, 32'd100, 32'd7, 2'b11, 32'd2, 32'd14, 32);
        waitIdle("divu_100_7");
        issue("multu_sh", MD_MULTU, 32'h1234_5678, 32'h10, 2'b11, 32'h1, 32'h2345_6780, 32);
        waitIdle("multu_sh");

        // MTLO keeps HI, MTHI keeps LO; both write one cycle after accept.
        issue("mtlo", MD_MTLO, 32'h0000_1234, 32'h0, 2'b01, lastHi, 32'h0000_1234, 0);
        waitIdle("mtlo");
        issue("mthi", MD_MTHI, 32'hABCD_0000, 32'h0, 2'b10, 32'hABCD_0000, lastLo, 0);
        waitIdle("mthi");

        // Reserved opcode is ignored.
        issue("op6", 3'd6, 32'h1, 32'h1, 2'b00, 32'h0, 32'h0, 0);
        check("op6_busy", 64'(bus.busy), 64'd0);

        // start together with cancel in IDLE is dropped.
        bus.cancel = 1'b1;
        issue("cancel_start", MD_DIVU, 32'd9, 32'd3, 2'b00, 32'h0, 32'h0, 0);
        bus.cancel = 1'b0;
        check("cancel_start_busy", 64'(bus.busy), 64'd0);

        // Cancel in RUN: no write, idle on the next edge.
        issue("divu_cancel", MD_DIVU, 32'd1000, 32'd3, 2'b00, 32'h0, 32'h0, 0);
        repeat (9) @(negedge clk);
        bus.cancel = 1'b1;
        @(negedge clk);
        check("cancel_busy",  64'(bus.busy), 64'd0);
        check("cancel_state", 64'(dbgState), 64'(S_IDLE));
        bus.cancel = 1'b0;
        repeat (40) @(negedge clk);

        // Reset in RUN: outputs return to reset values, no write.
        issue("divu_reset", MD_DIVU, 32'd1000, 32'd3, 2'b00, 32'h0, 32'h0, 0);
        repeat (9) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_busy",    64'(bus.busy),    64'd0);
        check("midrst_hlWrite", 64'(bus.hlWrite), 64'd0);
        check("midrst_dinHi",   64'(bus.dinHi),   64'd0);
        check("midrst_dinLo",   64'(bus.dinLo),   64'd0);
        rst    = 1'b1;
        lastHi = '0;
        lastLo = '0;
        repeat (40) @(negedge clk);
        issue("mtlo_post_rst", MD_MTLO, 32'h0000_5555, 32'h0, 2'b01, lastHi, 32'h0000_5555, 0);
        waitIdle("mtlo_post_rst");

        // start pulsed while busy is ignored: exactly one write.
        issue("mult_busy", MD_MULT, 32'd7, 32'd6, 2'b11, 32'h0, 32'h0000_002A, 32);
        repeat (4) @(negedge clk);
        bus.start = 1'b1;
        bus.op    = MD_MTHI;
        bus.srcA  = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.start = 1'b0;
        waitIdle("mult_busy");

        // Back-to-back issues right after DONE.
        issue("b2b_divu", MD_DIVU, 32'hFFFF_FFFF, 32'h10, 2'b11, 32'h0000_000F, 32'h0FFF_FFFF, 32);
        waitIdle("b2b_divu");
        issue("b2b_multu", MD_MULTU, 32'd3, 32'd4, 2'b11, 32'h0, 32'h0000_000C, 32);
        waitIdle("b2b_multu");

        repeat (5) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
